// File: rtl/mult_pipe_param.sv
// Pipelined WIDTH x WIDTH multiplier (signed or unsigned per transaction).
// Partial products reduce through a registered binary adder tree, one tree level per stage.
module mult_pipe_param #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned TAG_W = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 sgn,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int unsigned LVL   = $clog2(WIDTH);
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned NODES = WIDTH - 1;

  logic [PW-1:0]                a_ext;
  logic [WIDTH-1:0][PW-1:0]     pp;
  logic [NODES-1:0][PW-1:0]     node_d;
  logic [NODES-1:0][PW-1:0]     node_q;
  logic [LVL-1:0][TAG_W-1:0]    tag_q;
  logic [LVL-1:0]               vld_q;
  logic                         stall;

  assign stall    = vld_q[LVL-1] & ~out_ready;
  assign in_ready = ~stall;

  // In signed mode the multiplicand is sign-extended and the MSB row of b carries weight -2^(W-1).
  assign a_ext = {{WIDTH{sgn & a[WIDTH-1]}}, a};

  for (genvar i = 0; i < WIDTH; i++) begin : g_pp
    if (i == WIDTH - 1) begin : g_msb
      assign pp[i] = b[i] ? (sgn ? -(a_ext << i) : (a_ext << i)) : '0;
    end else begin : g_row
      assign pp[i] = b[i] ? (a_ext << i) : '0;
    end
  end

  // Tree nodes are packed level by level: level k starts at WIDTH - (WIDTH >> (k-1)).
  for (genvar j = 0; j < WIDTH / 2; j++) begin : g_l1
    assign node_d[j] = pp[2*j] + pp[2*j+1];
  end

  for (genvar k = 2; k <= LVL; k++) begin : g_lvl
    for (genvar j = 0; j < (WIDTH >> k); j++) begin : g_node
      assign node_d[WIDTH - (WIDTH >> (k-1)) + j] =
        node_q[WIDTH - (WIDTH >> (k-2)) + 2*j] + node_q[WIDTH - (WIDTH >> (k-2)) + 2*j + 1];
    end
  end

  // Whole pipeline moves together; a stall freezes every stage, bubbles included.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      node_q <= '0;
      tag_q  <= '0;
    end else if (!stall) begin
      vld_q  <= {vld_q[LVL-2:0], in_valid};
      node_q <= node_d;
      tag_q  <= {tag_q[LVL-2:0], in_tag};
    end
  end

  assign out_valid = vld_q[LVL-1];
  assign p         = node_q[NODES-1];
  assign out_tag   = tag_q[LVL-1];

endmodule

// File: tb/tb_mult_pipe_param.sv
// Bench for mult_pipe_param at WIDTH 4, 8 and 16: vector table, exhaustive and random
// streams against an integer reference model, backpressure and mid-stream reset.
module tb_mult_pipe_param;

  localparam int unsigned TW = 8;
  localparam int unsigned NV = 15;

  typedef struct {
    logic [31:0] p;
    logic [7:0]  tag;
    int          cyc;
    bit          timed;
  } exp_t;

  typedef struct {
    logic [1:0]  dut;
    logic [15:0] a;
    logic [15:0] b;
    logic        sgn;
    logic [31:0] p;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  in_valid_v, in_ready_v, out_valid_v, out_ready_v;
  logic [15:0] a_s, b_s;
  logic        sgn_s;
  logic [7:0]  tag_s;
  logic [7:0]  p4;
  logic [15:0] p8;
  logic [31:0] p16;
  logic [7:0]  ot4, ot8, ot16;
  logic [1:0]  act;
  logic        bp_en, timed_en;
  logic [31:0] drv_exp;
  logic [31:0] cur_p;
  logic [7:0]  cur_t;
  logic        hold_v;
  logic [31:0] hold_p;
  logic [7:0]  hold_t;
  int          total, bad, cyc;
  exp_t        exp_q[$];
  vec_t        vt[NV];

  always #5 clk = ~clk;

  mult_pipe_param #(.WIDTH(4), .TAG_W(TW)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .a(a_s[3:0]), .b(b_s[3:0]), .sgn(sgn_s), .in_tag(tag_s),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .p(p4), .out_tag(ot4));

  mult_pipe_param #(.WIDTH(8), .TAG_W(TW)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .a(a_s[7:0]), .b(b_s[7:0]), .sgn(sgn_s), .in_tag(tag_s),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .p(p8), .out_tag(ot8));

  mult_pipe_param #(.WIDTH(16), .TAG_W(TW)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .a(a_s), .b(b_s), .sgn(sgn_s), .in_tag(tag_s),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]), .p(p16), .out_tag(ot16));

  always_comb begin
    case (act)
      2'd0:    begin cur_p = 32'(p4);  cur_t = ot4;  end
      2'd1:    begin cur_p = 32'(p8);  cur_t = ot8;  end
      default: begin cur_p = p16;      cur_t = ot16; end
    endcase
  end

  function automatic int lvl(input logic [1:0] g);
    return (g == 2'd0) ? 2 : (g == 2'd1) ? 3 : 4;
  endfunction

  // Reference: interpret operands as plain integers, multiply, keep 2W bits.
  function automatic logic [31:0] model(input logic [1:0] g, input logic [15:0] a,
                                        input logic [15:0] b, input logic s);
    int     w;
    longint av, bv, pr;
    w  = (g == 2'd0) ? 4 : (g == 2'd1) ? 8 : 16;
    av = longint'(a) & ((longint'(1) << w) - 1);
    bv = longint'(b) & ((longint'(1) << w) - 1);
    if (s && av >= (longint'(1) << (w - 1))) av = av - (longint'(1) << w);
    if (s && bv >= (longint'(1) << (w - 1))) bv = bv - (longint'(1) << w);
    pr = av * bv;
    return 32'(pr & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Output monitor and scoreboard for the active instance, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      exp_q.delete();
      hold_v = 1'b0;
    end else begin
      total++;
      if (in_ready_v[act] !== ~(out_valid_v[act] & ~out_ready_v[act])) begin
        bad++;
        $display("FAIL in_ready: got %b want %b", in_ready_v[act],
                 ~(out_valid_v[act] & ~out_ready_v[act]));
      end
      if (hold_v) begin
        total++;
        if (out_valid_v[act] !== 1'b1 || cur_p !== hold_p || cur_t !== hold_t) begin
          bad++;
          $display("FAIL stall_hold: got v=%b p=%h t=%h want v=1 p=%h t=%h",
                   out_valid_v[act], cur_p, cur_t, hold_p, hold_t);
        end
      end
      hold_v = out_valid_v[act] & ~out_ready_v[act];
      hold_p = cur_p;
      hold_t = cur_t;
      if (out_valid_v[act] && out_ready_v[act]) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output: got p=%h t=%h want no output", cur_p, cur_t);
        end else begin
          e = exp_q.pop_front();
          if (cur_p !== e.p || cur_t !== e.tag) begin
            bad++;
            $display("FAIL product: got p=%h t=%h want p=%h t=%h", cur_p, cur_t, e.p, e.tag);
          end
          if (e.timed) begin
            total++;
            if (cyc != e.cyc + lvl(act)) begin
              bad++;
              $display("FAIL latency: got %0d want %0d", cyc - e.cyc, lvl(act));
            end
          end
        end
      end
      if (in_valid_v[act] && in_ready_v[act])
        exp_q.push_back('{drv_exp, tag_s, cyc, timed_en});
    end
  end

  // Downstream ready: random on the active instance under backpressure, else always ready.
  always @(posedge clk) begin
    #1;
    out_ready_v = 3'b111;
    if (bp_en) out_ready_v[act] = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s,
                      input logic [7:0] t, input logic [31:0] e);
    int guard;
    a_s = a; b_s = b; sgn_s = s; tag_s = t; drv_exp = e;
    in_valid_v = '0;
    in_valid_v[act] = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!in_ready_v[act] && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 200) begin
      total++; bad++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles want accept", guard);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid_v = '0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    in_valid_v = '0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
    end
    idle(6);
  endtask

  initial begin
    rst = 1'b1; in_valid_v = '0; a_s = '0; b_s = '0; sgn_s = 1'b0; tag_s = '0;
    act = 2'd0; bp_en = 1'b0; timed_en = 1'b0; drv_exp = '0;
    total = 0; bad = 0; cyc = 0; hold_v = 1'b0;

    vt[0]  = '{2'd0, 16'h0008, 16'h0008, 1'b1, 32'h0000_0040};
    vt[1]  = '{2'd0, 16'h000F, 16'h0001, 1'b1, 32'h0000_00FF};
    vt[2]  = '{2'd0, 16'h000F, 16'h000F, 1'b0, 32'h0000_00E1};
    vt[3]  = '{2'd0, 16'h0007, 16'h0007, 1'b1, 32'h0000_0031};
    vt[4]  = '{2'd0, 16'h000F, 16'h000F, 1'b1, 32'h0000_0001};
    vt[5]  = '{2'd1, 16'h00FF, 16'h00FF, 1'b0, 32'h0000_FE01};
    vt[6]  = '{2'd1, 16'h00FF, 16'h00FF, 1'b1, 32'h0000_0001};
    vt[7]  = '{2'd1, 16'h0080, 16'h007F, 1'b1, 32'h0000_C080};
    vt[8]  = '{2'd1, 16'h0080, 16'h0080, 1'b1, 32'h0000_4000};
    vt[9]  = '{2'd1, 16'h007F, 16'h007F, 1'b0, 32'h0000_3F01};
    vt[10] = '{2'd2, 16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001};
    vt[11] = '{2'd2, 16'h8000, 16'h8000, 1'b1, 32'h4000_0000};
    vt[12] = '{2'd2, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001};
    vt[13] = '{2'd2, 16'h8000, 16'h7FFF, 1'b1, 32'hC000_8000};
    vt[14] = '{2'd2, 16'h8000, 16'h7FFF, 1'b0, 32'h3FFF_8000};

    repeat (3) @(posedge clk);
    #1;
    chk("in_ready_during_rst", 32'(in_ready_v), 32'h7);
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid_v), 32'h0);
    chk("rst_p4", 32'(p4), 32'h0);
    chk("rst_p8", 32'(p8), 32'h0);
    chk("rst_p16", p16, 32'h0);
    chk("rst_tags", {8'h0, ot4, ot8, ot16}, 32'h0);

    // Fixed vectors, streamed back to back within one width (alternating modes included).
    timed_en = 1'b1;
    for (int i = 0; i < NV; i++) begin
      act = vt[i].dut;
      send(vt[i].a, vt[i].b, vt[i].sgn, 8'(i), vt[i].p);
      if (i == NV - 1) drain();
      else if (vt[i+1].dut != vt[i].dut) drain();
    end

    // WIDTH=4 exhaustive, unsigned then signed, no gaps.
    act = 2'd0;
    for (int s = 0; s < 2; s++) begin
      for (int x = 0; x < 256; x++) begin
        send(16'(x / 16), 16'(x % 16), 1'(s), 8'(x),
             model(2'd0, 16'(x / 16), 16'(x % 16), 1'(s)));
      end
    end
    drain();

    // WIDTH=8 random operands with sgn toggling every transaction.
    act = 2'd1;
    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom); rb = 16'($urandom);
      send(ra, rb, 1'(i % 2), 8'(i), model(2'd1, ra, rb, 1'(i % 2)));
    end
    drain();

    // Backpressure: 20 tagged pairs with random downstream ready.
    timed_en = 1'b0;
    bp_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      logic [15:0] ra, rb;
      logic        rs;
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom_range(0, 1));
      send(ra, rb, rs, 8'(100 + i), model(2'd1, ra, rb, rs));
    end
    drain();
    bp_en = 1'b0;
    idle(3);

    // Reset with a full WIDTH=16 pipeline while a new pair is also offered.
    act = 2'd2;
    for (int i = 0; i < 6; i++) begin
      send(16'(1234 * (i + 1)), 16'(77 + i), 1'b0, 8'(i), model(2'd2, 16'(1234 * (i + 1)), 16'(77 + i), 1'b0));
    end
    rst = 1'b1;
    a_s = 16'h5555; b_s = 16'h3333;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid_v = '0;
    chk("midrst_out_valid", 32'(out_valid_v[2]), 32'h0);
    chk("midrst_p", p16, 32'h0);
    chk("midrst_tag", 32'(ot16), 32'h0);
    chk("midrst_in_ready", 32'(in_ready_v[2]), 32'h1);
    timed_en = 1'b1;
    send(16'hFFF0, 16'h0013, 1'b1, 8'hA5, model(2'd2, 16'hFFF0, 16'h0013, 1'b1));
    drain();

    // WIDTH=16 random, both modes.
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] ra, rb;
      logic        rs;
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom_range(0, 1));
      send(ra, rb, rs, 8'(i), model(2'd2, ra, rb, rs));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
